// File: rtl/y_signature_compactor.sv
// Folds handshaken samples of a wide result bus into a MISR signature, one
// SIG_W-bit chunk per cycle, then compares the signature against a golden value.
module y_signature_compactor #(
  parameter int               DATA_W      = 541,
  parameter int               SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED        = 32'hFFFFFFFF,
  parameter int               NUM_SAMPLES = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] y,
  input  logic              y_valid,
  output logic              y_ready,
  input  logic [SIG_W-1:0]  golden,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       sample_cnt,
  output logic              busy,
  output logic              done,
  output logic              match
);

  localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int BUF_W  = NCHUNK * SIG_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [15:0]      CNT_LAST = 16'(NUM_SAMPLES);

  typedef enum logic [2:0] {IDLE, ARMED, SHIFT, FINISH, DONE} state_t;

  state_t                        state_q, state_d;
  logic [NCHUNK-1:0][SIG_W-1:0]  buf_q, buf_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [SIG_W-1:0]              sig_q, sig_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic                          y_ready_q, y_ready_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          match_q, match_d;
  logic [SIG_W-1:0]              chunk;
  logic [SIG_W-1:0]              sig_step;

  // Capture buffer is zero-padded up to a whole number of chunks.
  assign chunk    = buf_q[idx_q];
  assign sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ chunk;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    match_d = match_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ARMED;
          sig_d   = SEED;
          cnt_d   = '0;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end
      ARMED: begin
        if (y_valid && y_ready_q) begin
          buf_d   = BUF_W'(y);
          cnt_d   = cnt_q + 16'd1;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sig_d = sig_step;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = (cnt_q == CNT_LAST) ? FINISH : ARMED;
        end
      end
      FINISH: begin
        match_d = (sig_q == golden);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered, derived from the state being entered.
    y_ready_d = (state_d == ARMED);
    busy_d    = (state_d inside {ARMED, SHIFT, FINISH});
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      // NOTE: the capture buffer is reset too, so a fresh run never folds stale data.
      state_q   <= IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      sig_q     <= SEED;
      cnt_q     <= '0;
      y_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      y_ready_q <= y_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
    end
  end

  assign y_ready    = y_ready_q;
  assign signature  = sig_q;
  assign sample_cnt = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign match      = match_q;

endmodule

// File: tb/tb_y_signature_compactor.sv
// Self-checking bench: one default-parameter instance for handshake, restart and
// reset runs, and one SEED=0 / single-sample instance for exact signature values.
module tb_y_signature_compactor;

  localparam int          DATA_W = 541;
  localparam int          NCHUNK = 17;
  localparam int          NS     = 21;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED_A = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, start_a, y_valid_a, y_ready_a, busy_a, done_a, match_a;
  logic [DATA_W-1:0] y_a;
  logic [31:0]       golden_a, sig_a;
  logic [15:0]       cnt_a;

  logic              rst_b, start_b, y_valid_b, y_ready_b, busy_b, done_b, match_b;
  logic [DATA_W-1:0] y_b;
  logic [31:0]       golden_b, sig_b;
  logic [15:0]       cnt_b;

  y_signature_compactor dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .y(y_a), .y_valid(y_valid_a),
    .y_ready(y_ready_a), .golden(golden_a), .signature(sig_a), .sample_cnt(cnt_a),
    .busy(busy_a), .done(done_a), .match(match_a)
  );

  y_signature_compactor #(.SEED(32'h0), .NUM_SAMPLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .y(y_b), .y_valid(y_valid_b),
    .y_ready(y_ready_b), .golden(golden_b), .signature(sig_b), .sample_cnt(cnt_b),
    .busy(busy_b), .done(done_b), .match(match_b)
  );

  int                n_checks = 0;
  int                n_pass   = 0;
  logic [31:0]       exp_q[$];
  logic [DATA_W-1:0] samp[NS];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] c);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ c;
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [DATA_W-1:0] yv);
    logic [NCHUNK*32-1:0] b;
    logic [31:0]          r;
    b = {3'b000, yv};
    r = s;
    for (int k = 0; k < NCHUNK; k++) r = misr_step(r, b[k*32 +: 32]);
    return r;
  endfunction

  task automatic check_idle_a(input string tag);
    check({tag, "_ready"}, y_ready_a, 0);
    check({tag, "_busy"},  busy_a,    0);
    check({tag, "_done"},  done_a,    0);
    check({tag, "_match"}, match_a,   0);
    check({tag, "_sig"},   sig_a,     SEED_A);
    check({tag, "_cnt"},   cnt_a,     0);
  endtask

  // Full run on dut_a with y_valid held high. abort_smp / pulse_smp pick the
  // sample during whose folding rst (at chunk 8) or a stray start is applied.
  task automatic run_a(input int abort_smp, input int pulse_smp);
    int          accepted = 0;
    int          low_run  = 0;
    int          guard    = 0;
    logic [31:0] e;
    e = SEED_A;
    for (int i = 0; i < NS; i++) e = fold(e, samp[i]);
    exp_q.push_back(e);
    golden_a  = e;
    start_a   = 1'b1;
    y_valid_a = 1'b1;
    y_a       = samp[0];
    tick();
    start_a = 1'b0;
    check("arm_ready", y_ready_a, 1);
    check("arm_busy",  busy_a,    1);
    check("arm_done",  done_a,    0);
    check("arm_match", match_a,   0);
    check("arm_sig",   sig_a,     SEED_A);
    check("arm_cnt",   cnt_a,     0);
    while (!done_a && guard < 2000) begin
      guard++;
      if (y_ready_a) begin
        if (accepted >= NS) begin
          check("extra_ready", y_ready_a, 0);
          break;
        end
        if (accepted > 0) check("low_len", low_run, NCHUNK);
        y_a = samp[accepted];
        accepted++;
        low_run = 0;
        tick();
        check("cnt_step",    cnt_a,     accepted);
        check("ready_pulse", y_ready_a, 0);
      end else begin
        low_run++;
        if (accepted - 1 == abort_smp && low_run == 9) begin
          rst_a = 1'b1;
          tick();
          rst_a     = 1'b0;
          y_valid_a = 1'b0;
          check_idle_a("abort");
          void'(exp_q.pop_front());
          return;
        end
        if (accepted - 1 == pulse_smp && low_run == 5) start_a = 1'b1;
        tick();
        start_a = 1'b0;
        if (accepted - 1 == pulse_smp && low_run == 5) begin
          check("ign_busy", busy_a, 1);
          check("ign_cnt",  cnt_a,  accepted);
        end
      end
    end
    y_valid_a = 1'b0;
    if (!done_a) check("done_timeout", done_a, 1);
    check("n_samples", accepted, NS);
    check("tail_low",  low_run,  NCHUNK + 1);
    e = exp_q.pop_front();
    check("sig_a",     sig_a,   e);
    check("match_a",   match_a, 1);
    check("busy_done", busy_a,  0);
  endtask

  // Single-sample run on dut_b; expected signature is a hand-derived constant.
  task automatic run_b(input string tag, input logic [DATA_W-1:0] yv,
                       input logic [31:0] gold, input logic [31:0] exp_sig,
                       input logic exp_match);
    int          lat = 0;
    logic [31:0] e;
    exp_q.push_back(exp_sig);
    golden_b = gold;
    start_b  = 1'b1;
    tick();
    start_b = 1'b0;
    check({tag, "_ready"}, y_ready_b, 1);
    y_b       = yv;
    y_valid_b = 1'b1;
    tick();
    y_valid_b = 1'b0;
    while (!done_b && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, NCHUNK + 1);
    e = exp_q.pop_front();
    check({tag, "_sig"},   sig_b,   e);
    check({tag, "_match"}, match_b, exp_match);
    check({tag, "_cnt"},   cnt_b,   1);
  endtask

  initial begin
    logic [NCHUNK*32-1:0] tmp;
    logic [DATA_W-1:0]    one;
    logic [31:0]          held;

    for (int i = 0; i < NS; i++) begin
      for (int w = 0; w < NCHUNK; w++) tmp[w*32 +: 32] = $urandom();
      samp[i] = tmp[DATA_W-1:0];
    end

    rst_a = 1'b1; start_a = 1'b0; y_valid_a = 1'b0; y_a = '0; golden_a = '0;
    rst_b = 1'b1; start_b = 1'b0; y_valid_b = 1'b0; y_b = '0; golden_b = '0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_idle_a("reset");
    check("reset_b_sig", sig_b, 0);
    tick();
    check_idle_a("idle_hold");

    // Exact signature values with SEED=0 and a single sample.
    one = '0;
    run_b("zero", one, 32'h0, 32'h0000_0000, 1'b1);
    one = '0; one[0] = 1'b1;
    run_b("bit0", one, 32'h0001_0000, 32'h0001_0000, 1'b1);
    one = '0; one[32] = 1'b1;
    run_b("bit32", one, 32'h0000_8000, 32'h0000_8000, 1'b1);
    one = '0; one[540] = 1'b1;
    run_b("bit540", one, 32'h1000_0000, 32'h1000_0000, 1'b1);
    one = '0; one[0] = 1'b1;
    run_b("mism", one, 32'h0001_0001, 32'h0001_0000, 1'b0);

    // Full-width runs: stray start in SHIFT, restart from DONE, mid-run reset.
    run_a(-1, 3);
    held = sig_a;
    tick();
    tick();
    check("hold_sig",  sig_a,  held);
    check("hold_cnt",  cnt_a,  NS);
    check("hold_done", done_a, 1);
    run_a(-1, -1);
    run_a(1, -1);
    tick();
    check_idle_a("post_abort");
    run_a(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/y_signature_compactor.md
Name: y_signature_compactor

Overview:
- Downstream consumer of the fuzzed design's wide result bus `y`, which is 541 bits wide.
- Captures one `y` sample per handshake and folds it into a 32-bit MISR signature, one 32-bit chunk per cycle.
- After NUM_SAMPLES samples, compares the signature against a golden value and flags pass or fail.
- Replaces per-cycle dumping of the full bus with one compact signature per run for cross-tool (synthesised vs. RTL) equivalence checks.

Parameters:
- DATA_W, 541, width of the sampled `y` bus.
- SIG_W, 32, signature width and chunk width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, signature value loaded on reset and on start.
- NUM_SAMPLES, 21, number of samples folded per run (range 1..65535).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a new run.
- y  input  DATA_W  result bus from the design under test.
- y_valid  input  1  `y` is presented this cycle.
- y_ready  output  1  block can accept a sample this cycle.
- golden  input  SIG_W  expected signature; sampled in the FINISH state.
- signature  output  SIG_W  current MISR value.
- sample_cnt  output  16  number of samples accepted in this run.
- busy  output  1  high in ARMED, SHIFT and FINISH.
- done  output  1  run complete; held until start or rst.
- match  output  1  signature equals golden; valid while done is high.

Behaviour:
- Reset (rst sampled high):
  - state=IDLE, signature=SEED, sample_cnt=0.
  - y_ready=0, busy=0, done=0, match=0, chunk index=0, capture buffer=0.
  - rst overrides every other input, including mid-run.
- NCHUNK = ceil(DATA_W/SIG_W), which is 17 at the defaults.
  - Chunk k = buf[k*SIG_W +: SIG_W].
  - The top chunk is zero-extended; at the defaults, bits 31:29 of chunk 16 are 0.
- MISR step: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ chunk.
- IDLE:
  - y_ready=0.
  - start -> ARMED; signature<=SEED, sample_cnt<=0.
- ARMED:
  - y_ready=1 (registered output, high throughout ARMED).
  - y_valid && y_ready -> buf<=y, sample_cnt<=sample_cnt+1, chunk index<=0, -> SHIFT.
  - start is ignored.
- SHIFT:
  - y_ready=0; y_valid is ignored.
  - One MISR step per cycle using chunk[index]; index increments each cycle.
  - After the step on chunk NCHUNK-1:
    - if sample_cnt==NUM_SAMPLES -> FINISH;
    - otherwise -> ARMED.
- Throughput: a sample accepted in cycle t is fully folded at the edge ending cycle t+NCHUNK. y_ready is high again in cycle t+NCHUNK+1, so there is exactly NCHUNK cycles of y_ready low per sample.
- FINISH (one cycle): match<=(signature==golden), done<=1 -> DONE.
- DONE:
  - busy=0, done=1; signature, sample_cnt and match hold.
  - start -> ARMED with the same effects as from IDLE; done<=0 and match<=0 on that edge.
- start while busy is ignored. start and rst in the same cycle: rst wins.
- sample_cnt does not wrap, because the FSM leaves ARMED once NUM_SAMPLES is reached.

Test Plan:
- SEED=0, NUM_SAMPLES=1, y=0 -> done after 17 SHIFT cycles plus FINISH; signature=32'h00000000; match=1 with golden=0.
- SEED=0, NUM_SAMPLES=1, only y[0]=1 -> signature=32'h00010000 (16 shifts, no feedback).
  - Only y[32]=1 -> 32'h00008000.
  - Only y[540]=1 -> 32'h10000000.
- Handshake timing: defaults, y_valid held high continuously.
  - y_ready is high for exactly 1 cycle, then low for 17 cycles, repeated 21 times.
  - sample_cnt steps 1..21; done rises 1 cycle after the last chunk.
- Mismatch: SEED=0, NUM_SAMPLES=1, only y[0]=1, golden=32'h00010001 -> done=1, match=0.
- Reset mid-run: assert rst during SHIFT with index=8 -> next cycle state=IDLE, signature=SEED, sample_cnt=0, all flags 0.
  - A subsequent start plus full run gives the same signature as an uninterrupted run.
- Restart: in DONE pulse start; also pulse start during SHIFT.
  - The SHIFT pulse is ignored.
  - The DONE pulse clears done/match, reloads SEED, and a repeat of the same stimulus reproduces an identical signature.
